// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : RV32M execute-stage unit. Single-cycle registered multiply,
//                32-iteration restoring divide, early-out special cases,
//                stall (BUSY) and one-cycle completion pulse (VALID).
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESETn,
    input  logic            START,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OP_A,
    input  logic [XLEN-1:0] OP_B,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            VALID,
    output logic [XLEN-1:0] RESULT
);

    localparam int              CW     = $clog2(XLEN);
    localparam logic [XLEN-1:0] C_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] C_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   C_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    // r_op_a doubles as the dividend shift register: each divide iteration
    // shifts the dividend MSB out and the new quotient bit into the LSB, so
    // after the last iteration it holds the unsigned quotient.
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [XLEN-1:0] r_rem;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_func3;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_result;

    // ---------------- start-time decode ----------------
    logic            w_accept;
    logic            w_signed_div;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_val;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;

    assign w_accept      = START && !FLUSH && RESETn;
    assign w_signed_div  = !FUNC3[0];
    assign w_div_zero    = (OP_B == '0);
    assign w_ovf         = w_signed_div && (OP_A == C_MIN) && (OP_B == C_ONES);
    assign w_special     = FUNC3[2] && (w_div_zero || w_ovf);
    // Divide-by-zero takes precedence; B=-1 can never also be zero anyway.
    assign w_special_val = w_div_zero ? (FUNC3[1] ? OP_A : C_ONES)
                                      : (FUNC3[1] ? '0   : C_MIN);
    assign w_abs_a       = (w_signed_div && OP_A[XLEN-1]) ? -OP_A : OP_A;
    assign w_abs_b       = (w_signed_div && OP_B[XLEN-1]) ? -OP_B : OP_B;

    // ---------------- multiply datapath ----------------
    logic              w_mul_a_sgn;
    logic              w_mul_b_sgn;
    logic [2*XLEN-1:0] w_mul_a;
    logic [2*XLEN-1:0] w_mul_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;

    // MULH (01) signs both operands, MULHSU (10) signs only A, MULHU (11) none.
    assign w_mul_a_sgn = (r_func3 == 2'b01) || (r_func3 == 2'b10);
    assign w_mul_b_sgn = (r_func3 == 2'b01);
    assign w_mul_a     = {{XLEN{w_mul_a_sgn & r_op_a[XLEN-1]}}, r_op_a};
    assign w_mul_b     = {{XLEN{w_mul_b_sgn & r_op_b[XLEN-1]}}, r_op_b};
    assign w_prod      = w_mul_a * w_mul_b;
    assign w_mul_res   = (r_func3 == 2'b00) ? w_prod[XLEN-1:0]
                                            : w_prod[2*XLEN-1:XLEN];

    // ---------------- divide datapath ----------------
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_dvd_nx;
    logic [XLEN-1:0] w_q_fin;
    logic [XLEN-1:0] w_r_fin;
    logic [XLEN-1:0] w_div_res;
    logic            w_last;

    // The shifted partial remainder keeps its carry-out bit so divisors with
    // the MSB set compare correctly; the difference itself always fits XLEN.
    assign w_rem_sh  = {r_rem, r_op_a[XLEN-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_op_b});
    assign w_diff    = w_rem_sh[XLEN-1:0] - r_op_b;
    assign w_rem_nx  = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
    assign w_dvd_nx  = {r_op_a[XLEN-2:0], w_ge};
    assign w_q_fin   = r_neg_q ? -w_dvd_nx : w_dvd_nx;
    assign w_r_fin   = r_neg_r ? -w_rem_nx : w_rem_nx;
    assign w_div_res = r_func3[1] ? w_r_fin : w_q_fin;
    assign w_last    = (r_cnt == C_LAST);

    // State register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, stall request and completion pulse
    always_comb begin
        w_next = r_state;
        BUSY   = 1'b0;
        VALID  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    BUSY = 1'b1;
                    if (!FUNC3[2]) begin
                        w_next = S_MUL;
                    end else if (w_special) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_DIV;
                    end
                end
            end
            S_MUL: begin
                BUSY   = 1'b1;
                w_next = FLUSH ? S_IDLE : S_DONE;
            end
            S_DIV: begin
                BUSY = 1'b1;
                if (FLUSH) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                VALID  = !FLUSH;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, divide iteration and result register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_func3  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_func3 <= FUNC3[1:0];
                        r_op_a  <= FUNC3[2] ? w_abs_a : OP_A;
                        r_op_b  <= FUNC3[2] ? w_abs_b : OP_B;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_neg_q <= FUNC3[2] && w_signed_div
                                   && (OP_A[XLEN-1] ^ OP_B[XLEN-1]);
                        r_neg_r <= FUNC3[2] && w_signed_div && OP_A[XLEN-1];
                        if (w_special) begin
                            r_result <= w_special_val;
                        end
                    end
                end
                S_MUL: begin
                    if (!FLUSH) begin
                        r_result <= w_mul_res;
                    end
                end
                S_DIV: begin
                    if (!FLUSH) begin
                        r_op_a <= w_dvd_nx;
                        r_rem  <= w_rem_nx;
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_result <= w_div_res;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign RESULT = r_result;

endmodule
`default_nettype wire
